// File: rtl/bias3_pkg.sv
// Shared types and constants for the layer-3 bias delta generator.
// Holds lane geometry, update strobe codes, FSM encoding and the 16-bit saturator.
package bias3_pkg;

   localparam int LANES = 4;
   localparam int DW    = 16;

   localparam logic [LANES-1:0] SEL_UPD  = 4'b1111;
   localparam logic [LANES-1:0] CTRL_UPD = 4'b1111;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      SCALE = 2'd1,
      ISSUE = 2'd2
   } state_t;

   // Callers sign-extend to 64 bits so one function serves every datapath width.
   function automatic logic signed [DW-1:0] sat_dw(input logic signed [63:0] x);
      if (x > 64'sh0000_0000_0000_7fff)
         return 16'sh7fff;
      else if (x < 64'shffff_ffff_ffff_8000)
         return 16'sh8000;
      else
         return x[DW-1:0];
   endfunction

endpackage

// File: rtl/bias3_lane_scale.sv
// Combinational lane scaler: delta = sat16(-floor(acc * lr / 2^FRAC)).
// No state; shared across lanes by the parent during SCALE.
module bias3_lane_scale
   import bias3_pkg::*;
#(
   parameter int ACC_W = 32,
   parameter int FRAC  = 12
) (
   input  logic signed [ACC_W-1:0] acc,
   input  logic        [15:0]      lr,
   output logic signed [DW-1:0]    delta
);

   localparam int PW = ACC_W + 17;

   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] shifted;
   logic signed [PW-1:0] negated;

   // lr is unsigned, so a zero msb keeps it positive in the signed product.
   assign prod    = PW'(acc) * PW'($signed({1'b0, lr}));
   assign shifted = prod >>> FRAC;
   assign negated = -shifted;
   assign delta   = sat_dw(64'(negated));

endmodule

// File: rtl/bias3_delta_gen.sv
// Accumulates four output-error lanes per mini-batch, then emits scaled negated bias deltas.
// Strobe 5 cycles after the closing sample; samples offered while busy are dropped and flagged.
module bias3_delta_gen
   import bias3_pkg::*;
#(
   parameter int BATCH = 8,
   parameter int ACC_W = 32,
   parameter int FRAC  = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 err_valid,
   input  logic signed [DW-1:0] err_1,
   input  logic signed [DW-1:0] err_2,
   input  logic signed [DW-1:0] err_3,
   input  logic signed [DW-1:0] err_4,
   input  logic        [15:0]   lr,
   input  logic                 flush,
   output logic                 busy,
   output logic                 err_drop,
   output logic signed [DW-1:0] deltab3_1,
   output logic signed [DW-1:0] deltab3_2,
   output logic signed [DW-1:0] deltab3_3,
   output logic signed [DW-1:0] deltab3_4,
   output logic [LANES-1:0]     sel,
   output logic [LANES-1:0]     ctrl
);

   localparam int CNT_W = $clog2(BATCH + 1);

   state_t                  state, state_nxt;
   logic [1:0]              lane;
   logic [CNT_W-1:0]        cnt;
   logic signed [ACC_W-1:0] acc   [LANES];
   logic signed [DW-1:0]    err   [LANES];
   logic signed [DW-1:0]    delta [LANES];
   logic signed [DW-1:0]    lane_delta;
   logic                    accept, go;

   assign err[0] = err_1;
   assign err[1] = err_2;
   assign err[2] = err_3;
   assign err[3] = err_4;

   assign accept = (state == ACCUM) && err_valid;
   assign go     = (accept && (cnt == CNT_W'(BATCH - 1)))
                || ((state == ACCUM) && flush && ((cnt != '0) || err_valid));

   function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [DW-1:0]    e);
      logic signed [ACC_W:0] s;
      s = (ACC_W+1)'(a) + (ACC_W+1)'(e);
      if (s[ACC_W] != s[ACC_W-1])
         return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      return s[ACC_W-1:0];
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ACCUM;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      sel       = '0;
      ctrl      = '0;
      unique case (state)
         ACCUM: if (go) state_nxt = SCALE;
         SCALE: begin
            busy = 1'b1;
            if (lane == 2'(LANES - 1)) state_nxt = ISSUE;
         end
         ISSUE: begin
            busy      = 1'b1;
            sel       = SEL_UPD;
            ctrl      = CTRL_UPD;
            state_nxt = ACCUM;
         end
         default: state_nxt = ACCUM;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         lane     <= '0;
         err_drop <= 1'b0;
         for (int k = 0; k < LANES; k++) begin
            acc[k]   <= '0;
            delta[k] <= '0;
         end
      end else begin
         err_drop <= err_valid && (state != ACCUM);
         case (state)
            ACCUM: if (accept) begin
               cnt <= cnt + CNT_W'(1);
               for (int k = 0; k < LANES; k++) acc[k] <= acc_add(acc[k], err[k]);
            end
            // Lane index wraps to 0 on the last SCALE cycle, ready for the next batch.
            SCALE: begin
               delta[lane] <= lane_delta;
               lane        <= lane + 2'd1;
            end
            ISSUE: begin
               cnt <= '0;
               for (int k = 0; k < LANES; k++) acc[k] <= '0;
            end
            default: ;
         endcase
      end
   end

   bias3_lane_scale #(
      .ACC_W (ACC_W),
      .FRAC  (FRAC)
   ) u_lane_scale (
      .acc   (acc[lane]),
      .lr    (lr),
      .delta (lane_delta)
   );

   assign deltab3_1 = delta[0];
   assign deltab3_2 = delta[1];
   assign deltab3_3 = delta[2];
   assign deltab3_4 = delta[3];

endmodule

// File: tb/tb_bias3_delta_gen.sv
// Randomised self-checking bench for bias3_delta_gen against a batch-level arithmetic model.
module tb_bias3_delta_gen;

   localparam int BATCH = 8;
   localparam int ACC_W = 32;
   localparam int FRAC  = 12;

   logic               clk = 1'b0;
   logic               rst;
   logic               err_valid;
   logic signed [15:0] err_1, err_2, err_3, err_4;
   logic        [15:0] lr;
   logic               flush;
   logic               busy;
   logic               err_drop;
   logic signed [15:0] deltab3_1, deltab3_2, deltab3_3, deltab3_4;
   logic        [3:0]  sel;
   logic        [3:0]  ctrl;

   int     n_checks = 0;
   int     n_errors = 0;
   longint macc [4];
   longint mdelta [4];
   longint lane_lr [4];
   int     mcnt;

   always #5 clk = ~clk;

   bias3_delta_gen #(
      .BATCH (BATCH),
      .ACC_W (ACC_W),
      .FRAC  (FRAC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .err_valid (err_valid),
      .err_1     (err_1),
      .err_2     (err_2),
      .err_3     (err_3),
      .err_4     (err_4),
      .lr        (lr),
      .flush     (flush),
      .busy      (busy),
      .err_drop  (err_drop),
      .deltab3_1 (deltab3_1),
      .deltab3_2 (deltab3_2),
      .deltab3_3 (deltab3_3),
      .deltab3_4 (deltab3_4),
      .sel       (sel),
      .ctrl      (ctrl)
   );

   task automatic chk(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic longint clampl(input longint x, input longint lo, input longint hi);
      if (x < lo) return lo;
      if (x > hi) return hi;
      return x;
   endfunction

   // Bias delta = -floor(sum * lr / 2^FRAC), limited to the 16-bit signed range.
   function automatic longint model_delta(input longint a, input longint l);
      longint p, d, q;
      p = a * l;
      d = longint'(1) << FRAC;
      q = p / d;
      if ((p < 0) && (p % d != 0)) q = q - 1;
      return clampl(-q, -32768, 32767);
   endfunction

   function automatic longint got_delta(input int k);
      case (k)
         0:       return longint'(deltab3_1);
         1:       return longint'(deltab3_2);
         2:       return longint'(deltab3_3);
         default: return longint'(deltab3_4);
      endcase
   endfunction

   function automatic int rnd16();
      return int'($urandom_range(65535)) - 32768;
   endfunction

   function automatic void model_clear();
      for (int k = 0; k < 4; k++) macc[k] = 0;
      mcnt = 0;
   endfunction

   task automatic check_hold(input string tag);
      for (int k = 0; k < 4; k++) chk(tag, got_delta(k), mdelta[k]);
   endtask

   // Called in the first SCALE cycle; walks the update and checks timing and values.
   task automatic run_update(input bit vary_lr, input int drop_at);
      for (int k = 0; k < 4; k++) begin
         if (vary_lr) lr = 16'($urandom);
         lane_lr[k] = longint'(lr);
         chk("busy_scale", busy, 1);
         chk("sel_scale", sel, 0);
         if (k == drop_at) begin
            err_valid = 1'b1;
            err_1 = 16'(rnd16());
            err_2 = 16'(rnd16());
            err_3 = 16'(rnd16());
            err_4 = 16'(rnd16());
         end
         tick;
         err_valid = 1'b0;
         chk("err_drop_scale", err_drop, (k == drop_at) ? 1 : 0);
      end
      for (int k = 0; k < 4; k++) mdelta[k] = model_delta(macc[k], lane_lr[k]);
      chk("sel_issue", sel, 15);
      chk("ctrl_issue", ctrl, 15);
      chk("busy_issue", busy, 1);
      check_hold("delta_issue");
      tick;
      chk("sel_after", sel, 0);
      chk("ctrl_after", ctrl, 0);
      chk("busy_after", busy, 0);
      check_hold("delta_hold");
      model_clear();
   endtask

   task automatic send(input int a, input int b, input int c, input int d, input bit with_flush);
      err_1 = 16'(a);
      err_2 = 16'(b);
      err_3 = 16'(c);
      err_4 = 16'(d);
      err_valid = 1'b1;
      flush = with_flush;
      tick;
      err_valid = 1'b0;
      flush = 1'b0;
      chk("no_drop_accum", err_drop, 0);
      macc[0] = clampl(macc[0] + a, -(longint'(1) << 31), (longint'(1) << 31) - 1);
      macc[1] = clampl(macc[1] + b, -(longint'(1) << 31), (longint'(1) << 31) - 1);
      macc[2] = clampl(macc[2] + c, -(longint'(1) << 31), (longint'(1) << 31) - 1);
      macc[3] = clampl(macc[3] + d, -(longint'(1) << 31), (longint'(1) << 31) - 1);
      mcnt++;
      if ((mcnt == BATCH) || with_flush) run_update(1'b0, -1);
      else chk("busy_accum", busy, 0);
   endtask

   task automatic flush_only(input int drop_at);
      flush = 1'b1;
      tick;
      flush = 1'b0;
      if (mcnt > 0) begin
         run_update(1'b0, drop_at);
      end else begin
         chk("busy_empty_flush", busy, 0);
         tick;
         chk("sel_empty_flush", sel, 0);
         chk("busy_empty_flush2", busy, 0);
         check_hold("delta_empty_flush");
      end
   endtask

   initial begin
      rst = 1'b1;
      err_valid = 1'b0;
      flush = 1'b0;
      err_1 = '0; err_2 = '0; err_3 = '0; err_4 = '0;
      lr = 16'h0100;
      model_clear();
      for (int k = 0; k < 4; k++) mdelta[k] = 0;
      tick;
      tick;
      chk("rst_busy", busy, 0);
      chk("rst_sel", sel, 0);
      chk("rst_ctrl", ctrl, 0);
      chk("rst_drop", err_drop, 0);
      check_hold("rst_delta");
      rst = 1'b0;
      tick;

      // Basic batch with mixed signs.
      lr = 16'h0100;
      for (int i = 0; i < BATCH; i++) send(16, -32, 0, 4096, 1'b0);
      chk("t1_d1", longint'(deltab3_1), -8);
      chk("t1_d2", longint'(deltab3_2), 16);
      chk("t1_d4", longint'(deltab3_4), -2048);

      // Output saturation at both rails.
      lr = 16'h1000;
      for (int i = 0; i < BATCH; i++) send(32767, -32768, 0, 0, 1'b0);
      chk("t2_d1", longint'(deltab3_1), -32768);
      chk("t2_d2", longint'(deltab3_2), 32767);

      // Partial batch via flush, then a flush with nothing pending.
      for (int i = 0; i < 3; i++) send(100, 0, 0, 0, 1'b0);
      flush_only(-1);
      chk("t3_d1", longint'(deltab3_1), -300);
      flush_only(-1);

      // Floor rounding on tiny products.
      lr = 16'h0001;
      send(1, 0, 0, 0, 1'b1);
      chk("t6_pos", longint'(deltab3_1), 0);
      send(-1, 0, 0, 0, 1'b1);
      chk("t6_neg", longint'(deltab3_1), 1);

      // Sample offered during SCALE is dropped and not counted in the next batch.
      lr = 16'h0200;
      for (int i = 0; i < 4; i++) send(50, -50, 7, -7, 1'b0);
      flush_only(1);
      for (int i = 0; i < BATCH; i++) send(10, 20, -30, 40, 1'b0);

      // Reset in the middle of SCALE.
      for (int i = 0; i < BATCH - 1; i++) send(rnd16(), rnd16(), rnd16(), rnd16(), 1'b0);
      err_1 = 16'sd1000; err_2 = 16'sd1000; err_3 = 16'sd1000; err_4 = 16'sd1000;
      err_valid = 1'b1;
      tick;
      err_valid = 1'b0;
      tick;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_sel", sel, 0);
      chk("mid_rst_ctrl", ctrl, 0);
      chk("mid_rst_busy", busy, 0);
      for (int k = 0; k < 4; k++) mdelta[k] = 0;
      check_hold("mid_rst_delta");
      tick;
      rst = 1'b0;
      model_clear();
      tick;
      for (int i = 0; i < BATCH; i++) send(300, -300, 1, -1, 1'b0);

      // Learning rate changes every SCALE cycle.
      for (int i = 0; i < BATCH - 1; i++) send(rnd16(), rnd16(), rnd16(), rnd16(), 1'b0);
      err_1 = 16'sd2000; err_2 = -16'sd2000; err_3 = 16'sd5; err_4 = -16'sd5;
      err_valid = 1'b1;
      tick;
      err_valid = 1'b0;
      macc[0] += 2000; macc[1] -= 2000; macc[2] += 5; macc[3] -= 5;
      run_update(1'b1, -1);

      // Random batches: random lengths, gaps, flush style, lr and drop position.
      for (int b = 0; b < 24; b++) begin
         int n;
         bit flush_with_last;
         if ($urandom_range(3) == 0) lr = 16'($urandom);
         else lr = 16'($urandom_range(255));
         n = int'($urandom_range(1, BATCH));
         flush_with_last = $urandom_range(1) == 1;
         for (int i = 0; i < n; i++) begin
            int a, c2, e3, e4;
            bit last_flush;
            if ($urandom_range(1) == 1) begin
               a = rnd16(); c2 = rnd16(); e3 = rnd16(); e4 = rnd16();
            end else begin
               a = int'($urandom_range(400)) - 200;
               c2 = int'($urandom_range(400)) - 200;
               e3 = int'($urandom_range(400)) - 200;
               e4 = int'($urandom_range(400)) - 200;
            end
            last_flush = (i == n - 1) && (n < BATCH) && flush_with_last;
            send(a, c2, e3, e4, last_flush);
            for (int g = int'($urandom_range(2)); g > 0; g--) begin
               if (mcnt == 0) break;
               tick;
               chk("idle_busy", busy, 0);
               chk("idle_drop", err_drop, 0);
            end
         end
         if (mcnt > 0) flush_only(int'($urandom_range(4)) - 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
